dm_ctrl: RTL and testbench
==========================

DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of cycles spent in ACCESS without mem_ack before timeout (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline MEM-stage access request.
REQ-005 SHALL have port req_op  input  3  operation code: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-006 SHALL have port req_addr  input  32  byte address.
REQ-007 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-008 SHALL have port stall  output  1  freeze request to the pipeline.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_data  output  32  extended load result (0 for stores and errors).
REQ-011 SHALL have port err  output  1  error flag, valid with rsp_valid.
REQ-012 SHALL have ports mem_req, mem_we (output, 1 each), mem_addr (output, 32), mem_be (output, 4) and mem_wdata (output, 32), forming the memory request bus.
REQ-013 SHALL have ports mem_ack (input, 1) and mem_rdata (input, 32), forming the memory response.

Function
REQ-014 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-015 IDLE with req_valid=1 SHALL latch op/addr/wdata and go to ACCESS; otherwise remain in IDLE.
REQ-016 mem_req SHALL be registered, high exactly while in ACCESS; mem_* outputs SHALL be stable throughout ACCESS.
REQ-017 ACCESS with mem_ack=1 SHALL capture the result and go to RESP; a cycle-0-relative ack in the first ACCESS cycle is legal, giving minimum latency: req in cycle N, rsp_valid in cycle N+2.
REQ-018 RESP SHALL assert rsp_valid for exactly one cycle and return to IDLE; a new request is accepted only from IDLE.
REQ-019 stall SHALL be combinational: (IDLE and req_valid) or ACCESS.
REQ-020 mem_addr SHALL equal the latched address with bits [1:0] cleared.
REQ-021 Loads SHALL drive mem_we=0 and mem_be=1111.
REQ-022 SW SHALL drive mem_be=1111; SH SHALL drive 1100 if addr[1]=1, else 0011; SB SHALL drive 0001 shifted left by addr[1:0].
REQ-023 mem_wdata SHALL replicate the half (SH) or byte (SB) across all lanes.
REQ-024 Load extension SHALL be little-endian: byte k = mem_rdata[8k+7:8k], k=addr[1:0].
REQ-025 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass data through.
REQ-026 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-027 When the counter reaches MAX_WAIT with no ack, the FSM SHALL deassert mem_req, go to RESP with err=1 and rsp_data=0.
REQ-028 mem_ack SHALL be ignored outside ACCESS.
REQ-029 An ack in the same cycle the counter reaches MAX_WAIT SHALL win: normal completion, err=0.

Reset
REQ-030 reset SHALL force IDLE, clear the counter and latches, and set mem_req, mem_we, mem_be, rsp_valid, err and rsp_data to 0, immediately and asynchronously.
REQ-031 Reset during ACCESS SHALL abandon the access with no rsp_valid pulse.

Configuration
REQ-032 With macro DM_ALIGN_CHECK_EN defined, word ops with addr[1:0]!=0 and half ops with addr[0]=1 SHALL skip ACCESS (no mem_req) and go IDLE->RESP with err=1 and rsp_data=0.
REQ-033 Without DM_ALIGN_CHECK_EN, no alignment check SHALL exist: words ignore addr[1:0], halves ignore addr[0].

Structure
REQ-034 Package dm_pkg SHALL hold the op-code constants, the FSM state encoding and the MAX_WAIT default.
REQ-035 Load extension SHALL live in combinational sub-module dm_load_ext (inputs: rdata, addr[1:0], op; output: extended data).

Verification
REQ-036 LB at addr 0x1003, mem_rdata=0x80FF_0000, ack in first ACCESS cycle -> rsp_valid at N+2, rsp_data=0xFFFF_FF80, err=0.
REQ-037 SH at addr 0x2002, wdata=0x0000_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x2000, mem_we=1.
REQ-038 LW with no ack, MAX_WAIT=15 -> mem_req high 15 cycles, then rsp_valid with err=1 and rsp_data=0; stall falls in the RESP cycle.
REQ-039 LHU at addr 0x0001 -> with DM_ALIGN_CHECK_EN: no mem_req, err=1; without the macro: mem_be=1111 and rsp_data=zero-extended low half.
REQ-040 Reset asserted mid-ACCESS, then a late mem_ack -> mem_req=0, no rsp_valid, FSM in IDLE; the next LBU completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants, state encoding and lane helpers for dm_ctrl
// Optional feature macro: DM_ALIGN_CHECK_EN (used by misaligned()).
package dm_pkg;

  // Operation codes presented on req_op
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Byte enables; loads and full words touch every lane
  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] addr);
    logic [3:0] be;
    case (op)
      OP_SH:   be = addr[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << addr;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store value so the enabled lanes carry it
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    case (op)
      OP_SW:   d = wdata;
      OP_SH:   d = {2{wdata[15:0]}};
      OP_SB:   d = {4{wdata[7:0]}};
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr);
    logic m;
    case (op)
      OP_LW, OP_SW:         m = (addr != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = addr[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - little-endian lane select and sign/zero extension of load data
// Ports: rdata (raw memory word), addr (byte offset), op (load op code), data (extended result).
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr, 3'b000} +: 8];
    // Halves ignore addr[0]; an odd half address is either trapped upstream or tolerated
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LH:   data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data = {16'd0, lane_h};
      OP_LB:   data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data = {24'd0, lane_b};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - MEM-stage data memory controller (IDLE/ACCESS/RESP) with wait timeout
// Ports: clk, reset (async, active-high); req_valid/req_op/req_addr/req_wdata from the pipeline;
//        stall, rsp_valid, rsp_data, err back to the pipeline; mem_req/mem_we/mem_addr/mem_be/
//        mem_wdata to memory and mem_ack/mem_rdata from memory.
// Optional feature: define DM_ALIGN_CHECK_EN to trap misaligned word/half accesses.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Counter value at which the last permitted ACCESS cycle is running
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  dm_state_t   state, state_nx;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  wait_cnt;
  logic [31:0] load_data;
  logic        accept;
  logic        misalign;
  logic        timeout;

  assign accept = (state == ST_IDLE) && req_valid;

`ifdef DM_ALIGN_CHECK_EN
  assign misalign = misaligned(req_op, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // An ack arriving on the final cycle takes priority over the timeout
  assign timeout = (state == ST_ACCESS) && !mem_ack && (wait_cnt == LAST_CNT);

  assign stall = accept || (state == ST_ACCESS);

  dm_load_ext u_load_ext (
    .rdata (mem_rdata),
    .addr  (addr_lo_q),
    .op    (op_q),
    .data  (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nx = misalign ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || timeout) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request bus and response registers; the bus is loaded once on acceptance
  // so it stays stable for the whole ACCESS phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_LW;
      addr_lo_q <= 2'b00;
      wait_cnt  <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        op_q      <= req_op;
        addr_lo_q <= req_addr[1:0];
        wait_cnt  <= 8'd0;
        if (misalign) begin
          rsp_valid <= 1'b1;
          err       <= 1'b1;
          rsp_data  <= 32'd0;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= is_store(req_op);
          mem_be    <= store_be(req_op, req_addr[1:0]);
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wdata <= store_data(req_op, req_wdata);
        end
      end else if (state == ST_ACCESS) begin
        if (mem_ack || timeout) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= 4'b0000;
          rsp_valid <= 1'b1;
          err       <= !mem_ack;
          rsp_data  <= (mem_ack && !is_store(op_q)) ? load_data : 32'd0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - randomized self-checking bench for dm_ctrl against a transaction-level model
module tb_dm_ctrl;

  localparam int MW = 15;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dm_ctrl #(.MAX_WAIT(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Per-cycle expectations published by the driver, checked by the compare process
  bit          chk_en = 0;
  logic        e_stall, e_mreq, e_rv, e_err, e_we, e_wchk;
  logic [31:0] e_data, e_addr, e_wdata;
  logic [3:0]  e_be;

  // Observations of the last transaction, for the literal checks
  logic [31:0] last_data, obs_addr, obs_wdata;
  logic        last_err, last_rv, obs_we;
  logic [3:0]  obs_be;
  int          acc_seen, req_cyc, resp_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_mreq));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_mreq) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_be", 32'(mem_be), 32'(e_be));
        if (e_wchk) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_rv) begin
        chk("err", 32'(err), 32'(e_err));
        chk("rsp_data", rsp_data, e_data);
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic bit m_store(input int op);
    return op >= 5;
  endfunction

  function automatic logic [3:0] m_be(input int op, input logic [31:0] a);
    int off = int'(a % 4);
    if (op == 6) return (off >= 2) ? 4'hC : 4'h3;
    if (op == 7) return 4'(1 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] w);
    logic [31:0] h, b;
    h = w % 65536;
    b = w % 256;
    if (op == 6) return h * 65537;
    if (op == 7) return b * 32'h01010101;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * (a % 4))) % 256;
    h = (r >> (16 * ((a / 2) % 2))) % 65536;
    case (op)
      1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      2: return h;
      3: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      4: return b;
      default: return r;
    endcase
  endfunction

  function automatic bit m_mis(input int op, input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
    if (op == 0 || op == 5) return (a % 4) != 0;
    if (op == 1 || op == 2 || op == 6) return (a % 2) != 0;
    return 0;
`else
    return (op < 0) && (a == 0);
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic set_idle();
    req_valid = 1'b0;
    mem_ack   = 1'($urandom % 2);
    mem_rdata = $urandom;
    e_stall = 0; e_mreq = 0; e_rv = 0; e_wchk = 0;
  endtask

  task automatic do_txn(input int op, input logic [31:0] a, input logic [31:0] w,
                        input int dly, input logic [31:0] r);
    bit mis, tmo, done;
    int k;
    req_valid = 1'b1; req_op = 3'(op); req_addr = a; req_wdata = w;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    e_stall = 1; e_mreq = 0; e_rv = 0; e_wchk = 0;
    req_cyc = cyc; acc_seen = 0;
    mis = m_mis(op, a);
    tmo = 0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!mis) begin
      k = 0; done = 0;
      while (!done) begin
        e_stall = 1; e_mreq = 1; e_rv = 0;
        e_addr = a & 32'hFFFF_FFFC; e_we = m_store(op); e_be = m_be(op, a);
        e_wchk = m_store(op); e_wdata = m_wdata(op, w);
        mem_ack = (k == dly);
        mem_rdata = mem_ack ? r : $urandom;
        @(negedge clk);
        if (mem_req) acc_seen++;
        if (k == 0) begin
          obs_addr = mem_addr; obs_be = mem_be; obs_we = mem_we; obs_wdata = mem_wdata;
        end
        if (k == dly) done = 1;
        else if (k == MW - 1) begin done = 1; tmo = 1; end
        else begin k++; @(posedge clk); #1; end
      end
      @(posedge clk); #1;
    end
    e_stall = 0; e_mreq = 0; e_rv = 1; e_wchk = 0;
    e_err  = mis || tmo;
    e_data = (mis || tmo || m_store(op)) ? 32'd0 : m_load(op, a, r);
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    @(negedge clk);
    last_rv = rsp_valid; last_err = err; last_data = rsp_data; resp_cyc = cyc;
    @(posedge clk); #1;
    set_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    e_stall = 0; e_mreq = 0; e_rv = 0; e_err = 0; e_we = 0; e_wchk = 0;
    e_data = 0; e_addr = 0; e_wdata = 0; e_be = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle();
    chk_en = 1;
    @(posedge clk); #1;

    // LB sign extension with minimum latency
    do_txn(3, 32'h1003, 32'h0, 0, 32'h80FF_0000);
    chk("lb_data", last_data, 32'hFFFF_FF80);
    chk("lb_err", 32'(last_err), 0);
    chk("lb_rv", 32'(last_rv), 1);
    chk("lb_latency", 32'(resp_cyc - req_cyc), 2);

    // SH lane replication
    do_txn(6, 32'h2002, 32'h0000_BEEF, 2, 32'h0);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", obs_addr, 32'h2000);
    chk("sh_we", 32'(obs_we), 1);

    // LW timeout
    do_txn(0, 32'h100, 32'h0, 99, 32'h0);
    chk("to_req_cycles", 32'(acc_seen), 15);
    chk("to_err", 32'(last_err), 1);
    chk("to_data", last_data, 0);

    // Ack on the very last permitted cycle wins
    do_txn(4, 32'h7, 32'h0, MW - 1, 32'hC300_0000);
    chk("edge_err", 32'(last_err), 0);
    chk("edge_data", last_data, 32'h0000_00C3);
    chk("edge_req_cycles", 32'(acc_seen), 15);

    // LHU at odd address
    do_txn(2, 32'h1, 32'h0, 0, 32'h1234_8765);
`ifdef DM_ALIGN_CHECK_EN
    chk("lhu_req_cycles", 32'(acc_seen), 0);
    chk("lhu_err", 32'(last_err), 1);
    chk("lhu_data", last_data, 0);
`else
    chk("lhu_be", 32'(obs_be), 32'hF);
    chk("lhu_err", 32'(last_err), 0);
    chk("lhu_data", last_data, 32'h0000_8765);
`endif

    // Reset in the middle of ACCESS, followed by a stray ack
    chk_en = 0;
    req_valid = 1; req_op = 3'd0; req_addr = 32'h40; mem_ack = 0;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_mem_be", 32'(mem_be), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_mem_req", 32'(mem_req), 0);
    chk("late_ack_stall", 32'(stall), 0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("late_ack_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    set_idle();
    chk_en = 1;
    @(posedge clk); #1;
    do_txn(4, 32'h3, 32'h0, 1, 32'h9A00_0000);
    chk("post_rst_data", last_data, 32'h0000_009A);
    chk("post_rst_err", 32'(last_err), 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      do_txn(int'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 18)), $urandom);
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
